// File: rtl/end_screen_fetch.sv
// End-screen fetch stage: turns VGA draw coordinates into image ROM
// addresses and registers the returned colour index. The sync and blank
// signals are delayed so they stay aligned with that index. A game-over
// sequencer reveals the image top to bottom, a few lines per frame.
//
// Ports:
//   Clk, Reset          pixel clock, synchronous active-high reset
//   DrawX, DrawY        current pixel column / row
//   blank_in            1 = visible region
//   hs_in, vs_in        active-low syncs
//   game_over           level request for the end screen
//   rom_addr, rom_data  synchronous image ROM (1-cycle read latency)
//   index               colour index to the palette stage
//   end_active          end screen owns this pixel
//   blank_out, hs_out,  blank/syncs delayed 3 cycles
//   vs_out
//   wipe_done           image fully revealed
module end_screen_fetch #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int WIPE_STEP   = 8,
    parameter int BG_INDEX    = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              game_over,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        index,
    output logic              end_active,
    output logic              blank_out,
    output logic              hs_out,
    output logic              vs_out,
    output logic              wipe_done
);

    localparam logic [9:0] SCR_W    = 10'(IMG_W << SCALE_SHIFT);
    localparam logic [9:0] SCR_H    = 10'(IMG_H << SCALE_SHIFT);
    localparam logic [3:0] BG       = 4'(BG_INDEX);
    localparam logic [9:0] STEP     = 10'(WIPE_STEP);
    localparam logic [10:0] SCR_H11 = 11'(SCR_H);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        REVEAL,
        HOLD
    } state_t;

    state_t     state_q;
    logic [9:0] reveal_q;
    logic       wipe_done_q;
    logic       vs_prev_q;

    // Stage 1 registers
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              in_range1_q, in_range1_d;
    logic              revealed1_q, revealed1_d;
    logic              blank1_q, hs1_q, vs1_q;

    // Stage 2 registers (ROM read happens alongside)
    logic              in_range2_q, revealed2_q;
    logic              blank2_q, hs2_q, vs2_q;

    // Stage 3 registers
    logic [3:0]        index_q, index_d;
    logic              end_active_q, end_active_d;
    logic              blank3_q, hs3_q, vs3_q;

    logic [9:0]        xs, ys;
    logic [ADDR_W-1:0] ys_ext, addr_raw;
    logic              frame_start;
    logic [10:0]       reveal_sum;
    logic [9:0]        reveal_sat;
    logic              owns_screen;

    // Image width 160 = 128 + 32, so the row offset is two shifts and an add.
    always_comb begin
        xs          = DrawX >> SCALE_SHIFT;
        ys          = DrawY >> SCALE_SHIFT;
        ys_ext      = ADDR_W'(ys);
        addr_raw    = (ys_ext << 7) + (ys_ext << 5) + ADDR_W'(xs);
        in_range1_d = (DrawX < SCR_W) && (DrawY < SCR_H);
        rom_addr_d  = in_range1_d ? addr_raw : '0;
        revealed1_d = DrawY < reveal_q;
    end

    always_comb begin
        frame_start = vs_prev_q && !vs_in;
        reveal_sum  = {1'b0, reveal_q} + {1'b0, STEP};
        reveal_sat  = (reveal_sum >= SCR_H11) ? SCR_H : reveal_sum[9:0];
        owns_screen = (state_q == REVEAL) || (state_q == HOLD);
    end

    always_comb begin
        index_d      = (in_range2_q && revealed2_q) ? rom_data : BG;
        end_active_d = owns_screen && blank2_q;
    end

    // Sequencer: dropping game_over wins over a coincident frame start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            reveal_q    <= '0;
            wipe_done_q <= 1'b0;
            vs_prev_q   <= 1'b1;
        end else begin
            vs_prev_q <= vs_in;
            unique case (state_q)
                IDLE: begin
                    reveal_q    <= '0;
                    wipe_done_q <= 1'b0;
                    if (game_over) state_q <= ARM;
                end
                ARM: begin
                    if (!game_over) begin
                        state_q     <= IDLE;
                        reveal_q    <= '0;
                        wipe_done_q <= 1'b0;
                    end else if (frame_start) begin
                        state_q  <= REVEAL;
                        reveal_q <= STEP;
                    end
                end
                REVEAL: begin
                    if (!game_over) begin
                        state_q     <= IDLE;
                        reveal_q    <= '0;
                        wipe_done_q <= 1'b0;
                    end else if (frame_start) begin
                        reveal_q <= reveal_sat;
                        if (reveal_sum >= SCR_H11) begin
                            state_q     <= HOLD;
                            wipe_done_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!game_over) begin
                        state_q     <= IDLE;
                        reveal_q    <= '0;
                        wipe_done_q <= 1'b0;
                    end else begin
                        reveal_q    <= SCR_H;
                        wipe_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    reveal_q    <= '0;
                    wipe_done_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_q   <= '0;
            in_range1_q  <= 1'b0;
            revealed1_q  <= 1'b0;
            blank1_q     <= 1'b0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            in_range2_q  <= 1'b0;
            revealed2_q  <= 1'b0;
            blank2_q     <= 1'b0;
            hs2_q        <= 1'b1;
            vs2_q        <= 1'b1;
            index_q      <= '0;
            end_active_q <= 1'b0;
            blank3_q     <= 1'b0;
            hs3_q        <= 1'b1;
            vs3_q        <= 1'b1;
        end else begin
            rom_addr_q   <= rom_addr_d;
            in_range1_q  <= in_range1_d;
            revealed1_q  <= revealed1_d;
            blank1_q     <= blank_in;
            hs1_q        <= hs_in;
            vs1_q        <= vs_in;
            in_range2_q  <= in_range1_q;
            revealed2_q  <= revealed1_q;
            blank2_q     <= blank1_q;
            hs2_q        <= hs1_q;
            vs2_q        <= vs1_q;
            index_q      <= index_d;
            end_active_q <= end_active_d;
            blank3_q     <= blank2_q;
            hs3_q        <= hs2_q;
            vs3_q        <= vs2_q;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign index      = index_q;
    assign end_active = end_active_q;
    assign blank_out  = blank3_q;
    assign hs_out     = hs3_q;
    assign vs_out     = vs3_q;
    assign wipe_done  = wipe_done_q;

endmodule

// File: tb/tb_end_screen_fetch.sv
// Bench for end_screen_fetch: directed steps with randomized pixels,
// checked against a frame-counting reference model and a ROM image model.
module tb_end_screen_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        blank_in, hs_in, vs_in, game_over;
    logic [14:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  index;
    logic        end_active, blank_out, hs_out, vs_out, wipe_done;

    always #5 Clk = ~Clk;

    end_screen_fetch dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in),
        .game_over(game_over), .rom_addr(rom_addr), .rom_data(rom_data),
        .index(index), .end_active(end_active), .blank_out(blank_out),
        .hs_out(hs_out), .vs_out(vs_out), .wipe_done(wipe_done)
    );

    function automatic logic [3:0] img(int a);
        return 4'((a * 5) ^ (a >> 6));
    endfunction

    always @(posedge Clk) rom_data <= img(int'(rom_addr));

    typedef struct {
        bit rng, rev, blank, hs, vs;
        int addr;
    } ent_t;

    ent_t q[$];
    bit   armed;
    int   frames;
    bit   vsprev;
    int   e_addr, e_index, e_act, e_blank, e_hs, e_vs, e_done;
    int   passed = 0, total = 0, errs = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int line_now();
        if (!armed) return 0;
        return (frames * 8 > 480) ? 480 : frames * 8;
    endfunction

    // One clock: model the edge from stable inputs, then compare at negedge.
    task automatic cyc();
        ent_t e, o, nul;
        bit   act_pre;
        int   line;
        @(posedge Clk);
        nul = '{rng:0, rev:0, blank:0, hs:1, vs:1, addr:0};
        if (Reset) begin
            q.delete();
            q.push_back(nul);
            q.push_back(nul);
            armed = 0; frames = 0; vsprev = 1;
            e_addr = 0; e_index = 0; e_act = 0;
            e_blank = 0; e_hs = 1; e_vs = 1; e_done = 0;
        end else begin
            act_pre = armed && frames >= 1;
            line    = line_now();
            e.rng   = DrawX < 640 && DrawY < 480;
            e.rev   = int'(DrawY) < line;
            e.addr  = e.rng ? (int'(DrawY) / 4) * 160 + int'(DrawX) / 4 : 0;
            e.blank = blank_in; e.hs = hs_in; e.vs = vs_in;
            q.push_back(e);
            o = q.pop_front();
            e_addr  = e.addr;
            e_index = (o.rng && o.rev) ? int'(img(o.addr)) : 1;
            e_act   = int'(act_pre && o.blank);
            e_blank = o.blank; e_hs = o.hs; e_vs = o.vs;
            if (!armed) begin
                if (game_over) begin armed = 1; frames = 0; end
            end else if (!game_over) begin
                armed = 0; frames = 0;
            end else if (vsprev && !vs_in && frames < 60) begin
                frames++;
            end
            vsprev = vs_in;
            e_done = int'(armed && frames >= 60);
        end
        @(negedge Clk);
        chk("rom_addr", 32'(rom_addr), e_addr);
        chk("index", 32'(index), e_index);
        chk("end_active", 32'(end_active), e_act);
        chk("blank_out", 32'(blank_out), e_blank);
        chk("hs_out", 32'(hs_out), e_hs);
        chk("vs_out", 32'(vs_out), e_vs);
        chk("wipe_done", 32'(wipe_done), e_done);
    endtask

    task automatic rand_pix(bit focus);
        int l;
        DrawX = 10'($urandom_range(0, 799));
        if (focus && $urandom_range(0, 1) == 1) begin
            l = line_now() - int'($urandom_range(0, 1));
            DrawY = 10'((l < 0) ? 0 : l);
            DrawX = 10'($urandom_range(0, 639));
        end else begin
            DrawY = 10'($urandom_range(0, 524));
        end
        blank_in = (DrawX < 640 && DrawY < 480) ? ($urandom_range(0, 7) != 0) : 1'b0;
        hs_in    = ($urandom_range(0, 15) != 0);
    endtask

    task automatic frame(int len);
        for (int i = 0; i < len; i++) begin
            vs_in = (i >= 2);
            rand_pix(1);
            cyc();
        end
    endtask

    initial begin
        Reset = 1; DrawX = 0; DrawY = 0; blank_in = 0;
        hs_in = 1; vs_in = 1; game_over = 0;
        repeat (3) cyc();
        chk("reset_hs", 32'(hs_out), 1);
        chk("reset_index", 32'(index), 0);
        Reset = 0;

        for (int i = 0; i < 200; i++) begin
            rand_pix(0);
            vs_in = ($urandom_range(0, 20) != 0);
            cyc();
        end
        vs_in = 1;

        DrawX = 4; DrawY = 4; blank_in = 1; cyc();
        chk("addr_4_4", 32'(rom_addr), 161);
        DrawX = 700; DrawY = 10; cyc();
        chk("addr_oor", 32'(rom_addr), 0);
        DrawX = 639; DrawY = 479; cyc();
        chk("addr_max", 32'(rom_addr), 19199);
        cyc();
        chk("oor_index", 32'(index), 1);

        hs_in = 0; repeat (96) cyc();
        hs_in = 1; vs_in = 0; repeat (10) cyc();
        vs_in = 1; blank_in = 0; repeat (20) cyc();
        blank_in = 1; repeat (5) cyc();

        // game_over mid-frame: nothing shows until the next vsync fall
        game_over = 1;
        for (int i = 0; i < 30; i++) begin rand_pix(0); cyc(); end
        chk("arm_no_active", 32'(end_active), 0);
        vs_in = 0; cyc(); cyc();
        vs_in = 1;
        DrawX = 20; DrawY = 7; blank_in = 1; cyc();
        DrawY = 8; cyc();
        cyc();
        chk("y7_index", 32'(index), 32'(img(165)));
        cyc();
        chk("y8_index", 32'(index), 1);
        chk("y8_active", 32'(end_active), 1);
        for (int i = 0; i < 20; i++) begin rand_pix(1); cyc(); end
        for (int f = 2; f < 60; f++) frame(40);
        chk("wipe_pre", 32'(wipe_done), 0);
        frame(40);
        chk("wipe_done60", 32'(wipe_done), 1);
        repeat (3) frame(40);

        // abort in the same cycle as a frame start
        game_over = 0; cyc();
        game_over = 1;
        repeat (5) frame(40);
        vs_in = 0; game_over = 0; cyc();
        vs_in = 1;
        for (int i = 0; i < 6; i++) begin rand_pix(0); cyc(); end
        chk("abort_active", 32'(end_active), 0);
        chk("abort_done", 32'(wipe_done), 0);

        game_over = 1;
        repeat (62) frame(40);
        chk("hold_done", 32'(wipe_done), 1);
        Reset = 1; hs_in = 0; cyc();
        chk("rst_hs", 32'(hs_out), 1);
        chk("rst_done", 32'(wipe_done), 0);
        chk("rst_active", 32'(end_active), 0);
        Reset = 0; hs_in = 1;

        for (int i = 0; i < 3000; i++) begin
            rand_pix(1);
            vs_in = ($urandom_range(0, 30) != 0);
            if ($urandom_range(0, 400) == 0) game_over = ~game_over;
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
